// File: rtl/id_inst_queue_if.sv
// Valid/ready stream carrying one fetched instruction entry: {pc, inst, exception info}.
// The master drives valid and the payload. The slave returns ready.
interface id_inst_queue_if;
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        has_exception;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;

    modport master (
        output valid, pc, inst, has_exception, ecode, esubcode,
        input  ready
    );

    modport slave (
        input  valid, pc, inst, has_exception, ecode, esubcode,
        output ready
    );
endinterface

// File: rtl/id_inst_queue.sv
// Fetch->decode instruction FIFO. An entry is visible to decode one cycle after push (no bypass).
// in_ready depends on occupancy only, never on out_ready. Any flush empties the queue on the next edge.
module id_inst_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h03400000
) (
    input  logic                     clk,
    input  logic                     resetn,
    id_inst_queue_if.slave           in_if,
    id_inst_queue_if.master          out_if,
    input  logic                     ex_flush,
    input  logic                     ertn_flush,
    input  logic                     br_flush,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int             PW   = $clog2(DEPTH);
    localparam logic [PW:0]    FULL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        has_exc;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    logic   flush, push, pop;
    logic   in_ready, out_valid;
    entry_t wr_entry, head;

    assign flush     = ex_flush | ertn_flush | br_flush;
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_if.valid & in_ready & ~flush;
    assign pop       = out_valid & out_if.ready & ~flush;

    // Faulting fetches carry a harmless NOP so decode never acts on garbage SRAM data.
    assign wr_entry = '{
        pc:       in_if.pc,
        inst:     in_if.has_exception ? NOP_INST : in_if.inst,
        has_exc:  in_if.has_exception,
        ecode:    in_if.ecode,
        esubcode: in_if.esubcode
    };

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Stale entries stay in storage after a pop or flush, so the head is masked when empty.
    assign head = out_valid ? mem_q[rd_ptr_q] : '0;

    assign in_if.ready          = in_ready;
    assign out_if.valid         = out_valid;
    assign out_if.pc            = head.pc;
    assign out_if.inst          = head.inst;
    assign out_if.has_exception = head.has_exc;
    assign out_if.ecode         = head.ecode;
    assign out_if.esubcode      = head.esubcode;
    assign count                = count_q;

endmodule
